ro_sample_sequencer: RTL and testbench

Control FSM that sequences one ring-oscillator measurement per sample: clear the RO counters, enable the oscillators for a programmable gate window, let the counters settle, then launch one capture into the summing pipeline. It sits between the MMIO memory map (go, num_samples, window length) and `ro_top`'s RO array and adder tree. It throttles on the absorption FIFO's almost-full flag and reports done only after the last result has drained from the pipeline.

---
 rtl/ro_sample_sequencer_pkg.sv | 33 +++
 rtl/ro_sample_sequencer_timer.sv | 29 ++
 rtl/ro_sample_sequencer.sv | 172 +++++++++++++++++
 tb/tb_ro_sample_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ro_sample_sequencer_pkg.sv
// Shared types and default constants for the ring-oscillator sample sequencer.
// The count type matches the sample counter seen by the memory map.
package ro_sample_sequencer_pkg;

  localparam int DEF_RO_COUNT         = 20;
  localparam int DEF_NUM_SAMPLE_WIDTH = 48;
  localparam int DEF_WINDOW_WIDTH     = 16;
  localparam int DEF_SETTLE_CYCLES    = 3;
  localparam int DEF_PIPELINE_LATENCY = 5;

  typedef logic [DEF_NUM_SAMPLE_WIDTH-1:0] count_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SPACE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } t_seq_state;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The shared settle/drain counter must also hold PIPELINE_LATENCY+1.
  function automatic int hold_width(input int settle, input int latency);
    return $clog2(max_int(settle, latency) + 1) + 1;
  endfunction

endpackage

// File: rtl/ro_sample_sequencer_timer.sv
// Loadable down-counter; last is high while the count equals 1, i.e. in the
// final cycle of a loaded interval. Holds at zero once expired.
module ro_window_timer
  import ro_sample_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WINDOW_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             last
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign last = (count == WIDTH'(1));

endmodule

// File: rtl/ro_sample_sequencer.sv
// Sequences clear / gated run / settle / capture per RO sample, throttled by the
// absorption FIFO at sample boundaries; done follows the last result's drain.
module ro_sample_sequencer
  import ro_sample_sequencer_pkg::*;
#(
  parameter int N                = DEF_RO_COUNT,
  parameter int NUM_SAMPLE_WIDTH = DEF_NUM_SAMPLE_WIDTH,
  parameter int WINDOW_WIDTH     = DEF_WINDOW_WIDTH,
  parameter int SETTLE_CYCLES    = DEF_SETTLE_CYCLES,
  parameter int PIPELINE_LATENCY = DEF_PIPELINE_LATENCY
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        go,
  input  logic [NUM_SAMPLE_WIDTH-1:0] num_samples,
  input  logic [WINDOW_WIDTH-1:0]     window_cycles,
  input  logic                        fifo_almost_full,
  output logic                        ro_clr,
  output logic                        ro_en,
  output logic                        capture,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_SAMPLE_WIDTH-1:0] sample_count
);

  localparam int HOLD_WIDTH = hold_width(SETTLE_CYCLES, PIPELINE_LATENCY);
  localparam logic [HOLD_WIDTH-1:0] SETTLE_LOAD     = HOLD_WIDTH'(SETTLE_CYCLES);
  localparam logic [HOLD_WIDTH-1:0] DRAIN_LOAD      = HOLD_WIDTH'(PIPELINE_LATENCY);
  // An empty run still spends the accept cycle before draining, like a capture slot.
  localparam logic [HOLD_WIDTH-1:0] DRAIN_ZERO_LOAD = HOLD_WIDTH'(PIPELINE_LATENCY + 1);

  if (N < 1 || SETTLE_CYCLES < 1 || PIPELINE_LATENCY < 1) begin : g_bad_params
    $error("ro_sample_sequencer: N, SETTLE_CYCLES and PIPELINE_LATENCY must be >= 1");
  end

  t_seq_state                  state;
  logic [NUM_SAMPLE_WIDTH-1:0] num_q;
  logic [WINDOW_WIDTH-1:0]     window_q;

  logic                  accept;
  logic                  last_sample;
  logic                  run_load;
  logic                  run_last;
  logic                  hold_load;
  logic [HOLD_WIDTH-1:0] hold_value;
  logic                  hold_last;

  assign accept      = go && (state == S_IDLE || state == S_DONE);
  assign last_sample = (sample_count == num_q);

  always_comb begin
    run_load   = (state == S_CLEAR);
    hold_load  = 1'b0;
    hold_value = '0;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept && num_samples == '0) begin
          hold_load  = 1'b1;
          hold_value = DRAIN_ZERO_LOAD;
        end
      end
      S_RUN: begin
        if (run_last) begin
          hold_load  = 1'b1;
          hold_value = SETTLE_LOAD;
        end
      end
      S_CAPTURE: begin
        if (last_sample) begin
          hold_load  = 1'b1;
          hold_value = DRAIN_LOAD;
        end
      end
      default: ;
    endcase
  end

  ro_window_timer #(.WIDTH(WINDOW_WIDTH)) u_run_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (run_load),
    .load_value (window_q),
    .last       (run_last)
  );

  ro_window_timer #(.WIDTH(HOLD_WIDTH)) u_hold_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (hold_load),
    .load_value (hold_value),
    .last       (hold_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      num_q        <= '0;
      window_q     <= '0;
      sample_count <= '0;
      ro_clr       <= 1'b0;
      ro_en        <= 1'b0;
      capture      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      ro_clr  <= 1'b0;
      capture <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            num_q        <= num_samples;
            window_q     <= (window_cycles == '0) ? WINDOW_WIDTH'(1) : window_cycles;
            sample_count <= '0;
            done         <= 1'b0;
            busy         <= 1'b1;
            if (num_samples == '0) begin
              state <= S_DRAIN;
            end else if (fifo_almost_full) begin
              state <= S_WAIT_SPACE;
            end else begin
              state  <= S_CLEAR;
              ro_clr <= 1'b1;
            end
          end
        end
        S_WAIT_SPACE: begin
          if (!fifo_almost_full) begin
            state  <= S_CLEAR;
            ro_clr <= 1'b1;
          end
        end
        S_CLEAR: begin
          state <= S_RUN;
          ro_en <= 1'b1;
        end
        S_RUN: begin
          if (run_last) begin
            state <= S_SETTLE;
            ro_en <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (hold_last) begin
            state        <= S_CAPTURE;
            capture      <= 1'b1;
            sample_count <= sample_count + NUM_SAMPLE_WIDTH'(1);
          end
        end
        S_CAPTURE: begin
          // The FIFO flag is only consulted here, between samples.
          if (last_sample) begin
            state <= S_DRAIN;
          end else if (fifo_almost_full) begin
            state <= S_WAIT_SPACE;
          end else begin
            state  <= S_CLEAR;
            ro_clr <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (hold_last) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_sample_sequencer.sv
// Randomized bench: an event-timeline model predicts every output per cycle.
module tb_ro_sample_sequencer;

  localparam int NSW    = 48;
  localparam int WW     = 16;
  localparam int SETTLE = 3;
  localparam int LAT    = 5;
  localparam int MAXC   = 2048;

  logic           clk = 1'b0;
  logic           rst;
  logic           go;
  logic [NSW-1:0] num_samples;
  logic [WW-1:0]  window_cycles;
  logic           fifo_almost_full;
  logic           ro_clr, ro_en, capture, busy, done;
  logic [NSW-1:0] sample_count;

  int checks = 0;
  int errors = 0;

  logic       flag_tr [MAXC];
  logic [4:0] exp_sig [MAXC];
  longint     exp_cnt [MAXC];
  logic [4:0] obs_sig [MAXC];
  logic       prev_done;
  longint     prev_cnt;

  ro_sample_sequencer #(
    .N                (20),
    .NUM_SAMPLE_WIDTH (NSW),
    .WINDOW_WIDTH     (WW),
    .SETTLE_CYCLES    (SETTLE),
    .PIPELINE_LATENCY (LAT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .go               (go),
    .num_samples      (num_samples),
    .window_cycles    (window_cycles),
    .fifo_almost_full (fifo_almost_full),
    .ro_clr           (ro_clr),
    .ro_en            (ro_en),
    .capture          (capture),
    .busy             (busy),
    .done             (done),
    .sample_count     (sample_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Signal bits {ro_clr, ro_en, capture, busy, done}; go is at cycle 0.
  // Each sample starts at the first flag-low cycle c at/after its decision
  // cycle: clear at c+1, enable c+2..c+1+W, capture at c+W+SETTLE+2.
  task automatic build_expected(input int n, input int w, input logic pdone,
                                input longint pcnt, output int done_at);
    int weff, d, c, cap;
    weff = (w == 0) ? 1 : w;
    for (int k = 0; k < MAXC; k++) begin
      exp_sig[k] = 5'b00010;
      exp_cnt[k] = 0;
    end
    exp_sig[0] = {4'b0000, pdone};
    exp_cnt[0] = pcnt;
    d = 0;
    cap = 0;
    for (int s = 0; s < n; s++) begin
      c = d;
      while (flag_tr[c]) c++;
      exp_sig[c+1][4] = 1'b1;
      for (int k = c + 2; k <= c + 1 + weff; k++) exp_sig[k][3] = 1'b1;
      cap = c + weff + SETTLE + 2;
      exp_sig[cap][2] = 1'b1;
      for (int k = cap; k < MAXC; k++) exp_cnt[k] = s + 1;
      d = cap;
    end
    done_at = (n == 0) ? 1 + LAT + 1 : cap + LAT + 1;
    for (int k = done_at; k < MAXC; k++) exp_sig[k] = 5'b00001;
  endtask

  function automatic int first_idx(input int bitpos, input int from);
    for (int k = from; k < MAXC; k++) if (obs_sig[k][bitpos]) return k;
    return -1;
  endfunction

  // mode 0: flag low; 1: flag high cycles 15..35; 2: random flag.
  task automatic run_scenario(input string name, input int n, input int w,
                              input int mode, input bit spur);
    int done_at;
    logic [4:0] sig;
    for (int k = 0; k < MAXC; k++) begin
      obs_sig[k] = '0;
      case (mode)
        1:       flag_tr[k] = (k >= 15 && k <= 35);
        2:       flag_tr[k] = (k < 1000) && ($urandom_range(0, 3) == 0);
        default: flag_tr[k] = 1'b0;
      endcase
    end
    build_expected(n, w, prev_done, prev_cnt, done_at);
    for (int k = 0; k < done_at + 4; k++) begin
      @(posedge clk);
      #1;
      go = (k == 0) || (spur && k < done_at && ($urandom_range(0, 7) == 0 || k == done_at - 1));
      num_samples      = (k == 0) ? NSW'(n) : NSW'({$urandom(), $urandom()});
      window_cycles    = (k == 0) ? WW'(w) : WW'($urandom());
      fifo_almost_full = flag_tr[k];
      @(negedge clk);
      sig = {ro_clr, ro_en, capture, busy, done};
      obs_sig[k] = sig;
      check_eq($sformatf("%s_sig@%0d", name, k), 64'(sig), 64'(exp_sig[k]));
      check_eq($sformatf("%s_cnt@%0d", name, k), 64'(sample_count), 64'(exp_cnt[k]));
    end
    go = 1'b0;
    prev_done = 1'b1;
    prev_cnt = n;
  endtask

  task automatic run_reset_mid_run();
    int done_at;
    for (int k = 0; k < MAXC; k++) flag_tr[k] = 1'b0;
    build_expected(3, 10, prev_done, prev_cnt, done_at);
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk);
      #1;
      go = (k == 0);
      num_samples = 3;
      window_cycles = 10;
      fifo_almost_full = 1'b0;
      if (k < 5) begin
        @(negedge clk);
        check_eq($sformatf("rst_pre_sig@%0d", k),
                 64'({ro_clr, ro_en, capture, busy, done}), 64'(exp_sig[k]));
      end
    end
    check_eq("rst_in_run_en", 64'(ro_en), 64'(exp_sig[5][3]));
    rst = 1'b1;
    #1;
    check_eq("rst_async_sig", 64'({ro_clr, ro_en, capture, busy, done}), 64'(0));
    check_eq("rst_async_cnt", 64'(sample_count), 64'(0));
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_hold_sig", 64'({ro_clr, ro_en, capture, busy, done}), 64'(0));
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_eq($sformatf("rst_idle@%0d", k),
               64'({ro_clr, ro_en, capture, busy, done, sample_count}), 64'(0));
    end
    prev_done = 1'b0;
    prev_cnt = 0;
  endtask

  initial begin
    rst = 1'b1;
    go = 1'b0;
    num_samples = '0;
    window_cycles = '0;
    fifo_almost_full = 1'b0;
    prev_done = 1'b0;
    prev_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_sig", 64'({ro_clr, ro_en, capture, busy, done}), 64'(0));
    check_eq("reset_cnt", 64'(sample_count), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    run_scenario("basic", 2, 10, 0, 1'b0);
    check_eq("basic_cap0_cycle", 64'(first_idx(2, 0)), 64'(15));
    check_eq("basic_cap1_cycle", 64'(first_idx(2, 16)), 64'(30));
    check_eq("basic_done_cycle", 64'(first_idx(0, 1)), 64'(36));

    run_scenario("spurious", 2, 10, 0, 1'b1);

    run_scenario("zero", 0, 7, 0, 1'b1);
    check_eq("zero_done_cycle", 64'(first_idx(0, 1)), 64'(7));

    run_scenario("win0", 2, 0, 0, 1'b0);

    run_scenario("throttle", 2, 10, 1, 1'b0);
    check_eq("throttle_clr_cycle", 64'(first_idx(4, 16)), 64'(37));

    for (int i = 0; i < 6; i++)
      run_scenario($sformatf("rand%0d", i), $urandom_range(0, 4), $urandom_range(0, 12), 2, 1'b1);

    run_reset_mid_run();
    run_scenario("restart", 2, 10, 0, 1'b1);
    run_scenario("again", 1, 4, 2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
